mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the successor to the fixed two-cycle MEM-stage multiply path. It runs signed and unsigned multiply and divide, multiply-accumulate and multiply-subtract, and HI/LO moves at configurable width. A Busy handshake lets the hazard unit stall dependent instructions, and a Flush input lets a mispredicted branch cancel an in-flight operation.

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with MADD/MSUB accumulate.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_divzero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_signed_op;
    logic                 w_div_launch;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_is_div;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ok;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     w_quo_s;
    logic [WIDTH-1:0]     w_rem_s;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [2*WIDTH-1:0]   w_hilo;
    logic [2*WIDTH-1:0]   w_madd;
    logic [2*WIDTH-1:0]   w_msub;

    // Handshake: Start is taken only in IDLE when Flush is low; Busy stays high from the
    // accepting edge until the Done edge, and Busy is already low in the Done cycle.
    always_comb begin
        w_signed_op  = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        w_div_launch = (Op == OP_DIV) || (Op == OP_DIVU);
        w_a_neg      = w_signed_op && A[WIDTH-1];
        w_b_neg      = w_signed_op && B[WIDTH-1];
        w_abs_a      = w_a_neg ? -A : A;
        w_abs_b      = w_b_neg ? -B : B;
        w_is_div     = (r_op == OP_DIV) || (r_op == OP_DIVU);

        // Multiply: product shifts right, multiplier bits consumed from the LSB
        w_mul_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next   = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Divide: upper half is the partial remainder, lower half dividend/quotient
        w_div_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff   = w_div_shift - {1'b0, r_opnd};
        w_div_ok     = ~w_div_diff[WIDTH];
        w_div_next   = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ok};

        w_step       = w_is_div ? w_div_next : w_mul_next;

        w_quo_s      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_s      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_prod_s     = r_neg_q ? -r_acc : r_acc;
        w_hilo       = {r_hi, r_lo};
        w_madd       = w_hilo + w_prod_s;
        w_msub       = w_hilo - w_prod_s;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= OP_MULT;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        r_op <= Op;
                        if (Op == OP_MTHI) begin
                            r_hi      <= A;
                            r_done    <= 1'b1;
                            r_divzero <= 1'b0;
                        end else if (Op == OP_MTLO) begin
                            r_lo      <= A;
                            r_done    <= 1'b1;
                            r_divzero <= 1'b0;
                        end else if (w_div_launch && (B == '0)) begin
                            r_divzero <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_divzero <= 1'b0;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_busy    <= 1'b1;
                            r_state   <= S_CALC;
                            if (w_div_launch) begin
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opnd <= w_abs_b;
                            end else begin
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opnd <= w_abs_a;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        case (r_op)
                            OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod_s;
                            OP_DIV, OP_DIVU: begin
                                r_lo <= w_quo_s;
                                r_hi <= w_rem_s;
                            end
                            OP_MADD: {r_hi, r_lo} <= w_madd;
                            OP_MSUB: {r_hi, r_lo} <= w_msub;
                            default: ;
                        endcase
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_divzero;
    assign Hi      = r_hi;
    assign Lo      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomised bench for mul_div_unit at WIDTH=32 and WIDTH=8, with a
// reference model feeding an expected-result queue popped on each Done.
module tb_mul_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        st32, fl32, busy32, done32, dz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        st8, fl8, busy8, done8, dz8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    mul_div_unit #(.WIDTH(32)) u_dut32 (
        .Clk(clk), .Reset(rst), .Start(st32), .Op(op32), .A(a32), .B(b32), .Flush(fl32),
        .Busy(busy32), .Done(done32), .DivZero(dz32), .Hi(hi32), .Lo(lo32)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Reset(rst), .Start(st8), .Op(op8), .A(a8), .B(b8), .Flush(fl8),
        .Busy(busy8), .Done(done8), .DivZero(dz8), .Hi(hi8), .Lo(lo8)
    );

    // scoreboard
    logic [63:0] exp_q[$];
    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic        m_dz[2];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 32) ? done32 : done8;
    endfunction

    function automatic logic obs_dz(input int w);
        return (w == 32) ? dz32 : dz8;
    endfunction

    function automatic logic [63:0] pack(input int w, input logic [31:0] h, input logic [31:0] l);
        return (w == 32) ? {h, l} : {48'd0, h[7:0], l[7:0]};
    endfunction

    function automatic logic [63:0] obs_hilo(input int w);
        return (w == 32) ? {hi32, lo32} : {48'd0, hi8, lo8};
    endfunction

    // Reference model: signed arithmetic in 64-bit longint, results masked to w bits
    task automatic model(input int w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo,
                         output logic dz);
        logic [63:0] mask, ua, ub, p, acc, r;
        longint sa, sb;
        mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
        sa   = (w == 32) ? longint'($signed(a)) : longint'($signed(a[7:0]));
        sb   = (w == 32) ? longint'($signed(b)) : longint'($signed(b[7:0]));
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        acc  = ((({32'd0, hi}) & mask) << w) | (({32'd0, lo}) & mask);
        dz   = 1'b0;
        r    = acc;
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = ua * ub;
            OP_MADD:  r = acc + 64'(sa * sb);
            OP_MSUB:  r = acc - 64'(sa * sb);
            default:  r = acc;
        endcase
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                hi = 32'((r >> w) & mask);
                lo = 32'(r & mask);
            end
            OP_DIV: begin
                if (sb == 0) dz = 1'b1;
                else begin
                    lo = 32'(64'(sa / sb) & mask);
                    hi = 32'(64'(sa % sb) & mask);
                end
            end
            OP_DIVU: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    lo = 32'((ua / ub) & mask);
                    hi = 32'((ua % ub) & mask);
                end
            end
            OP_MTHI: hi = 32'(ua);
            default: lo = 32'(ua);
        endcase
    endtask

    // driver
    task automatic drive(input int w, input logic s, input logic f, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            st32 = s; fl32 = f; op32 = o; a32 = a; b32 = b;
        end else begin
            st8 = s; fl8 = f; op8 = o; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // evt: 0 none, 1 stray DIVU start, 2 flush, 3 reset -- applied at negedge evt_cyc
    task automatic run(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int evt, input int evt_cyc);
        int idx, n, busy_n;
        logic seen, imm, dz, busy_at_done;
        logic [31:0] nh, nl;
        idx = (w == 32) ? 0 : 1;
        nh  = m_hi[idx];
        nl  = m_lo[idx];
        model(w, op, a, b, nh, nl, dz);
        imm = (op == OP_MTHI) || (op == OP_MTLO) || dz;
        if (evt < 2) begin
            exp_q.push_back(pack(w, nh, nl));
            m_hi[idx] = nh;
            m_lo[idx] = nl;
            m_dz[idx] = dz;
        end
        @(negedge clk);
        drive(w, 1'b1, 1'b0, op, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, 1'b0, op, a, b);
        n = 0; busy_n = 0; seen = 1'b0; busy_at_done = 1'b0;
        while (!seen && n < w + 6) begin
            @(negedge clk);
            n++;
            if (evt != 0 && n == evt_cyc + 1) begin
                drive(w, 1'b0, 1'b0, op, a, b);
                rst = 1'b0;
                if (evt == 2) begin
                    chk("flush_busy", {63'd0, obs_busy(w)}, 64'd0);
                    chk("flush_hilo", obs_hilo(w), pack(w, m_hi[idx], m_lo[idx]));
                end
                if (evt == 3) begin
                    chk("rst_hilo32", {hi32, lo32}, 64'd0);
                    chk("rst_busy", {63'd0, busy32}, 64'd0);
                    chk("rst_done", {63'd0, done32}, 64'd0);
                    chk("rst_dz", {63'd0, dz32}, 64'd0);
                end
            end
            if (obs_busy(w)) busy_n++;
            if (obs_done(w)) begin
                seen = 1'b1;
                busy_at_done = obs_busy(w);
            end
            if (evt != 0 && n == evt_cyc) begin
                if (evt == 1) drive(w, 1'b1, 1'b0, OP_DIVU, 32'h10, 32'h0);
                if (evt == 2) drive(w, 1'b0, 1'b1, op, a, b);
                if (evt == 3) begin
                    rst = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        m_hi[k] = '0; m_lo[k] = '0; m_dz[k] = 1'b0;
                    end
                end
            end
        end
        if (evt < 2) begin
            chk("done_seen", {63'd0, seen}, 64'd1);
            if (seen) begin
                chk("hilo", obs_hilo(w), exp_q.pop_front());
                chk("latency", 64'(n), imm ? 64'd1 : 64'(w + 2));
                chk("busy_cycles", 64'(busy_n), imm ? 64'd0 : 64'(w + 1));
                chk("busy_at_done", {63'd0, busy_at_done}, 64'd0);
                chk("divzero", {63'd0, obs_dz(w)}, {63'd0, m_dz[idx]});
                @(negedge clk);
                chk("done_pulse", {63'd0, obs_done(w)}, 64'd0);
            end else begin
                void'(exp_q.pop_front());
            end
        end else begin
            chk("no_done", {63'd0, seen}, 64'd0);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        drive(32, 1'b0, 1'b0, OP_MULT, 32'd0, 32'd0);
        drive(8, 1'b0, 1'b0, OP_MULT, 32'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_hi[k] = '0; m_lo[k] = '0; m_dz[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hilo32", {hi32, lo32}, 64'd0);
        chk("reset_flags32", {61'd0, busy32, done32, dz32}, 64'd0);
        chk("reset_hilo8", {48'd0, hi8, lo8}, 64'd0);
        chk("reset_flags8", {61'd0, busy8, done8, dz8}, 64'd0);

        run(32, OP_MULT, 32'hFFFF_FFFF, 32'd5, 0, 0);
        chk("mult_lit", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFB);
        run(32, OP_MULTU, 32'hFFFF_FFFF, 32'd5, 0, 0);
        chk("multu_lit", {hi32, lo32}, 64'h0000_0004_FFFF_FFFB);
        run(32, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_lit", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
        run(32, OP_DIVU, 32'h10, 32'd0, 0, 0);
        chk("divzero_lit", {63'd0, dz32}, 64'd1);
        run(32, OP_MULT, 32'd3, 32'd4, 0, 0);
        chk("dz_cleared", {63'd0, dz32}, 64'd0);

        run(32, OP_MTHI, 32'd0, 32'd0, 0, 0);
        run(32, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0);
        run(32, OP_MADD, 32'd1, 32'd1, 0, 0);
        chk("madd_lit", {hi32, lo32}, 64'h0000_0001_0000_0000);
        run(32, OP_MSUB, 32'd1, 32'd2, 0, 0);
        chk("msub_lit", {hi32, lo32}, 64'h0000_0000_FFFF_FFFE);

        run(32, OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1, 5);
        run(32, OP_DIV, 32'h8765_4321, 32'h0000_0123, 2, 10);
        run(32, OP_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0);
        run(32, OP_MULTU, 32'h0000_0077, 32'h0000_0099, 3, 20);
        run(32, OP_MULT, 32'd3, 32'd4, 0, 0);
        chk("mult_after_rst", {hi32, lo32}, 64'd12);
        run(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div_wrap32", {hi32, lo32}, 64'h0000_0000_8000_0000);

        run(8, OP_DIV, 32'h80, 32'hFF, 0, 0);
        chk("div_wrap8", {48'd0, hi8, lo8}, 64'h0080);

        for (int i = 0; i < 24; i++) begin
            for (int w = 8; w <= 32; w += 24) begin
                rop = 3'($urandom_range(0, 5));
                ra  = $urandom;
                rb  = $urandom;
                if ((rop == OP_DIV || rop == OP_DIVU) && (i % 6 != 0)) begin
                    if (w == 8 && rb[7:0] == 8'd0) rb = 32'd1;
                    if (w == 32 && rb == 32'd0) rb = 32'd1;
                end
                run(w, rop, ra, rb, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
